// File: rtl/pdm_pkg.sv
// pdm_pkg: shared constants and helpers for the stereo PDM CIC front end
package pdm_pkg;
    localparam logic signed [1:0] PDM_POS = 2'sb01;
    localparam logic signed [1:0] PDM_NEG = 2'sb11;

    function automatic int cic_width(input int order, input int dec);
        return order * $clog2(dec) + 2;
    endfunction
endpackage

// File: rtl/pdm_stereo_cic_channel.sv
// cic_channel: one channel's integrator chain and pipelined comb section
module cic_channel
    import pdm_pkg::*;
#(
    parameter int ORDER     = 4,
    parameter int W         = 22,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 clear,
    input  logic                 tick,
    input  logic                 bit_in,
    input  logic                 latch,
    output logic [OUT_WIDTH-1:0] sample,
    output logic                 done
);
    logic signed [W-1:0] integ [ORDER];
    logic signed [W-1:0] dly [ORDER];
    logic signed [W-1:0] stage [ORDER+1];
    logic [ORDER:0] vld;
    logic signed [W-1:0] x;

    assign x = W'(bit_in ? PDM_POS : PDM_NEG);
    assign done = vld[ORDER];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < ORDER; i++) begin
                integ[i] <= '0;
                dly[i] <= '0;
            end
            for (int i = 0; i <= ORDER; i++) stage[i] <= '0;
            vld <= '0;
        end else if (clear) begin
            for (int i = 0; i < ORDER; i++) begin
                integ[i] <= '0;
                dly[i] <= '0;
            end
            for (int i = 0; i <= ORDER; i++) stage[i] <= '0;
            vld <= '0;
        end else begin
            if (tick) begin
                integ[0] <= integ[0] + x;
                for (int i = 1; i < ORDER; i++) integ[i] <= integ[i] + integ[i-1];
            end
            if (latch) stage[0] <= integ[ORDER-1];
            vld <= {vld[ORDER-1:0], latch};
            // one comb stage per cycle as the valid bit walks down the pipe
            for (int i = 0; i < ORDER; i++) begin
                if (vld[i]) begin
                    stage[i+1] <= stage[i] - dly[i];
                    dly[i] <= stage[i];
                end
            end
        end
    end

    if (W > OUT_WIDTH) begin : g_shift
        assign sample = stage[ORDER][W-1 -: OUT_WIDTH];
    end else begin : g_ext
        assign sample = OUT_WIDTH'(stage[ORDER]);
    end
endmodule

// File: rtl/pdm_stereo_cic.sv
// pdm_stereo_cic: stereo PDM capture, per-channel CIC decimation and a
// show-ahead frame FIFO with valid/ready output and sticky overflow.
module pdm_stereo_cic
    import pdm_pkg::*;
#(
    parameter int CLK_DIV    = 40,
    parameter int DECIMATION = 32,
    parameter int CIC_ORDER  = 4,
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter bit STEREO     = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 enable,
    input  logic                 pdm_data,
    output logic                 pdm_clk,
    output logic [OUT_WIDTH-1:0] out_left,
    output logic [OUT_WIDTH-1:0] out_right,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow,
    input  logic                 ovf_clr
);
    localparam int W  = cic_width(CIC_ORDER, DECIMATION);
    localparam int CW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DECIMATION);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [OUT_WIDTH-1:0] left;
        logic [OUT_WIDTH-1:0] right;
    } frame_t;

    if (CLK_DIV < 8) begin : g_bad_div
        $error("CLK_DIV must be at least 8 so the comb pipeline drains between ticks");
    end

    logic [CW-1:0] div_cnt;
    logic [DW-1:0] dec_cnt;
    logic [1:0] sync;
    logic tc, rise, fall, latch;

    assign tc = enable && div_cnt == CW'(CLK_DIV - 1);
    assign rise = tc && !pdm_clk;
    assign fall = tc && pdm_clk;
    assign latch = rise && dec_cnt == DW'(DECIMATION - 1);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sync <= '0;
            div_cnt <= '0;
            pdm_clk <= 1'b0;
            dec_cnt <= '0;
        end else begin
            sync <= {sync[0], pdm_data};
            div_cnt <= (!enable || tc) ? '0 : div_cnt + 1'b1;
            pdm_clk <= enable && (pdm_clk ^ tc);
            dec_cnt <= !enable ? '0 : dec_cnt + DW'(rise);
        end
    end

    frame_t wr_frame;
    logic l_done, wr_req;

    cic_channel #(.ORDER(CIC_ORDER), .W(W), .OUT_WIDTH(OUT_WIDTH)) u_left (
        .HCLK(HCLK), .HRESET(HRESET), .clear(!enable), .tick(fall), .bit_in(sync[1]),
        .latch(latch), .sample(wr_frame.left), .done(l_done)
    );

    if (STEREO) begin : g_right
        logic r_done;
        cic_channel #(.ORDER(CIC_ORDER), .W(W), .OUT_WIDTH(OUT_WIDTH)) u_right (
            .HCLK(HCLK), .HRESET(HRESET), .clear(!enable), .tick(rise), .bit_in(sync[1]),
            .latch(latch), .sample(wr_frame.right), .done(r_done)
        );
        assign wr_req = l_done && r_done;
    end else begin : g_mono
        assign wr_frame.right = '0;
        assign wr_req = l_done;
    end

    frame_t mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic empty, full, rd, wr;

    assign empty = wptr == rptr;
    assign full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    assign rd = !empty && out_ready;
    // a same-cycle pop frees the slot, so a full FIFO still accepts the write
    assign wr = wr_req && (!full || rd);
    assign out_valid = !empty;
    assign {out_left, out_right} = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge HCLK) begin
        if (wr) mem[wptr[AW-1:0]] <= wr_frame;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wptr <= '0;
            rptr <= '0;
            overflow <= 1'b0;
        end else begin
            wptr <= wptr + (AW+1)'(wr);
            rptr <= rptr + (AW+1)'(rd);
            overflow <= (wr_req && !wr) || (overflow && !ovf_clr);
        end
    end
endmodule

// File: tb/tb_pdm_stereo_cic.sv
// tb_pdm_stereo_cic: directed stimulus with a frame scoreboard and a
// decoupled output monitor for pdm_stereo_cic.
module tb_pdm_stereo_cic;
    localparam int CLK_DIV     = 8;
    localparam int DECIMATION  = 16;
    localparam int CIC_ORDER   = 3;
    localparam int OUT_WIDTH   = 16;
    localparam int FIFO_DEPTH  = 4;
    localparam int PERIOD      = 2 * CLK_DIV * DECIMATION;
    // 16th rising tick lands CLK_DIV cycles before a full period, then the comb pipe
    localparam int FIRST_WRITE = PERIOD - CLK_DIV + CIC_ORDER + 1;
    localparam logic [15:0] POS = 16'h1000;
    localparam logic [15:0] NEG = 16'hF000;

    logic HCLK = 0, HRESET = 1, enable = 0, out_ready = 0, ovf_clr = 0;
    logic pdm_clk, out_valid, overflow, pdm_data;
    logic [OUT_WIDTH-1:0] out_left, out_right;
    logic [1:0] mode = 0;

    assign pdm_data = mode == 2'd0 ? 1'b0 : mode == 2'd1 ? 1'b1 : mode == 2'd2 ? pdm_clk : !pdm_clk;

    pdm_stereo_cic #(
        .CLK_DIV(CLK_DIV), .DECIMATION(DECIMATION), .CIC_ORDER(CIC_ORDER),
        .OUT_WIDTH(OUT_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .STEREO(1)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .enable(enable), .pdm_data(pdm_data),
        .pdm_clk(pdm_clk), .out_left(out_left), .out_right(out_right),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit          care;
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int n_run = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic push(input int n, input logic [15:0] l, input logic [15:0] r);
        for (int i = 0; i < n; i++) sb.push_back('{care: i >= CIC_ORDER, l: l, r: r});
    endtask

    task automatic wait_drain(input int lim);
        int k = 0;
        while (sb.size() != 0 && k < lim) begin
            tick(1);
            k++;
        end
        check("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_phase(input logic [1:0] m, input int n, input logic [15:0] l, input logic [15:0] r);
        mode = m;
        tick(4);
        push(n, l, r);
        out_ready = 1;
        enable = 1;
        wait_drain(n * PERIOD + PERIOD);
        enable = 0;
        tick(4);
    endtask

    always @(negedge HCLK) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_frame: got %0h/%0h, none expected", out_left, out_right);
            end else begin
                e = sb.pop_front();
                if (e.care) begin
                    check("frame_left", out_left, e.l);
                    check("frame_right", out_right, e.r);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, rise_k, seen;
        tick(3);
        check("reset_state", {pdm_clk, out_valid, overflow, out_left, out_right}, 0);
        HRESET = 0;
        tick(2);

        run_phase(2'd1, 6, POS, POS);
        run_phase(2'd0, 6, NEG, NEG);
        run_phase(2'd2, 6, POS, NEG);
        run_phase(2'd3, 6, NEG, POS);

        // first rise, first write latency, and frame spacing
        mode = 1;
        tick(4);
        push(2, POS, POS);
        out_ready = 1;
        enable = 1;
        k = 0;
        rise_k = -1;
        while (!out_valid && k < 2 * PERIOD) begin
            tick(1);
            k++;
            if (pdm_clk && rise_k < 0) rise_k = k;
        end
        check("first_rise", rise_k, CLK_DIV);
        check("first_write", k, FIRST_WRITE);
        while (out_valid && k < 4 * PERIOD) begin
            tick(1);
            k++;
        end
        while (!out_valid && k < 4 * PERIOD) begin
            tick(1);
            k++;
        end
        check("frame_period", k, FIRST_WRITE + PERIOD);
        tick(2);
        enable = 0;
        wait_drain(4);
        tick(4);

        // overflow with stalled consumer, then enable drop mid-run
        mode = 1;
        tick(4);
        sb.push_back('{care: 0, l: POS, r: POS});
        sb.push_back('{care: 0, l: POS, r: POS});
        sb.push_back('{care: 0, l: POS, r: POS});
        sb.push_back('{care: 1, l: POS, r: POS});
        sb.push_back('{care: 1, l: POS, r: POS});
        out_ready = 0;
        enable = 1;
        tick(FIRST_WRITE + 4 * PERIOD - 4);
        check("ovf_before_drop", overflow, 0);
        check("fifo_valid_full", out_valid, 1);
        tick(8);
        check("ovf_set", overflow, 1);
        out_ready = 1;
        tick(1);
        out_ready = 0;
        tick(PERIOD + 4);
        k = 0;
        while (!pdm_clk && k < 4 * CLK_DIV) begin
            tick(1);
            k++;
        end
        check("pdm_high_before_drop", pdm_clk, 1);
        enable = 0;
        tick(1);
        check("pdm_clk_drop", pdm_clk, 0);
        check("fifo_kept", out_valid, 1);
        check("ovf_kept_disabled", overflow, 1);
        ovf_clr = 1;
        tick(1);
        ovf_clr = 0;
        check("ovf_clr", overflow, 0);
        out_ready = 1;
        wait_drain(20);
        tick(2);
        check("fifo_empty", out_valid, 0);

        // asynchronous reset mid-run
        mode = 0;
        out_ready = 0;
        sb.push_back('{care: 0, l: NEG, r: NEG});
        enable = 1;
        tick(FIRST_WRITE + 4);
        k = 0;
        while (!pdm_clk && k < 4 * CLK_DIV) begin
            tick(1);
            k++;
        end
        check("valid_before_reset", {pdm_clk, out_valid}, 2'b11);
        #3 HRESET = 1;
        #1 check("reset_async", {pdm_clk, out_valid, overflow, out_left, out_right}, 0);
        sb.delete();
        tick(2);
        HRESET = 0;
        seen = 0;
        for (int i = 0; i < FIRST_WRITE - 12; i++) begin
            tick(1);
            if (out_valid) seen++;
        end
        check("no_spurious_valid", seen, 0);
        enable = 0;
        tick(4);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
